// File: rtl/aes_pkg.sv
// Shared types and constants for the AES command serializer.
package aes_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StKsize,
        StKey,
        StProc,
        StGap
    } state_e;

    localparam logic [1:0] KSIZE_128     = 2'd0;
    localparam logic [1:0] KSIZE_192     = 2'd1;
    localparam logic [1:0] KSIZE_256     = 2'd2;
    localparam logic [1:0] KSIZE_INVALID = 2'd3;

    localparam logic [5:0] LEN_128 = 6'd16;
    localparam logic [5:0] LEN_192 = 6'd24;
    localparam logic [5:0] LEN_256 = 6'd32;

    localparam logic [7:0] OP_ENCRYPT = 8'h01;

    // Anything that is not 192 or 256 falls back to a 128-bit key.
    function automatic logic [5:0] key_len(input logic [1:0] ksize);
        case (ksize)
            KSIZE_192: key_len = LEN_192;
            KSIZE_256: key_len = LEN_256;
            default:   key_len = LEN_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_cmd_serializer.sv
// Serializes an AES request (data, key length, key, op) into a contiguous byte stream.
// Optional macro AES_SERIALIZER_KSIZE_CHECK_EN rejects req_ksize=3 with an err pulse.
module aes_cmd_serializer
    import aes_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_data,
    input  logic [255:0] req_key,
    input  logic [1:0]   req_ksize,
    input  logic [7:0]   req_op,
    output logic         we,
    output logic [7:0]   Indata,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [5:0] GAP_LAST = (GAP_CYCLES == 0) ? 6'd0 : 6'(GAP_CYCLES - 1);

    state_e         state;
    logic [5:0]     cnt;
    logic [127:0]   data_sr;
    logic [255:0]   key_sr;
    logic [5:0]     klen;
    logic [7:0]     op;
    logic           accept;
    logic           start;

    assign accept = req_valid && req_ready;

`ifdef AES_SERIALIZER_KSIZE_CHECK_EN
    assign start = accept && (req_ksize != KSIZE_INVALID);

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= accept && (req_ksize == KSIZE_INVALID);
        end
    end
`else
    assign start = accept;
    assign err   = 1'b0;
`endif

    // Outputs are registered: each edge loads the byte that is visible during the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= 6'd0;
            we        <= 1'b0;
            Indata    <= 8'h00;
            done      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StData;
                        cnt       <= 6'd0;
                        we        <= 1'b1;
                        Indata    <= req_data[127:120];
                        data_sr   <= {req_data[119:0], 8'h00};
                        key_sr    <= req_key;
                        klen      <= key_len(req_ksize);
                        op        <= req_op;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                StData: begin
                    if (cnt == 6'd15) begin
                        state  <= StKsize;
                        cnt    <= 6'd0;
                        Indata <= {2'b00, klen};
                    end else begin
                        cnt     <= cnt + 6'd1;
                        Indata  <= data_sr[127:120];
                        data_sr <= {data_sr[119:0], 8'h00};
                    end
                end
                StKsize: begin
                    state  <= StKey;
                    cnt    <= 6'd0;
                    Indata <= key_sr[255:248];
                    key_sr <= {key_sr[247:0], 8'h00};
                end
                StKey: begin
                    if (cnt == klen - 6'd1) begin
                        state  <= StProc;
                        cnt    <= 6'd0;
                        Indata <= op;
                    end else begin
                        cnt    <= cnt + 6'd1;
                        Indata <= key_sr[255:248];
                        key_sr <= {key_sr[247:0], 8'h00};
                    end
                end
                StProc: begin
                    cnt    <= 6'd0;
                    we     <= 1'b0;
                    Indata <= 8'h00;
                    done   <= 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state     <= StIdle;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        state <= StGap;
                    end
                end
                StGap: begin
                    if (cnt == GAP_LAST) begin
                        state     <= StIdle;
                        cnt       <= 6'd0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cmd_serializer.sv
// Directed, table-driven bench for aes_cmd_serializer (GAP_CYCLES = 0 build).
module tb_aes_cmd_serializer;

    localparam int GAP = 0;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_data;
    logic [255:0] req_key;
    logic [1:0]   req_ksize;
    logic [7:0]   req_op;
    logic         we;
    logic [7:0]   Indata;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;

    aes_cmd_serializer #(
        .GAP_CYCLES(GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_key  (req_key),
        .req_ksize(req_ksize),
        .req_op   (req_op),
        .we       (we),
        .Indata   (Indata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [255:0] key;
        logic [1:0]   ksize;
        logic [7:0]   op;
        int           exp_len;
        logic [7:0]   exp_kbyte;
        bit           exp_err;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input vec_t v, input int i);
        int klen;
        klen = int'(v.exp_kbyte);
        if (i < 16) return v.data[127 - 8*i -: 8];
        if (i == 16) return v.exp_kbyte;
        if (i < 17 + klen) return v.key[255 - 8*(i - 17) -: 8];
        return v.op;
    endfunction

    task automatic drive_req(input vec_t v, input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({name, "_ready_wait"}, req_ready, 1);
        req_data  = v.data;
        req_key   = v.key;
        req_ksize = v.ksize;
        req_op    = v.op;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Sends one request and checks the resulting frame; optional valid pulse / reset mid-frame.
    task automatic run_frame(input vec_t v, input string name, input int pulse_at,
                             input int reset_at);
        int n;
        int bad;
        int stray;
        n = 0;
        bad = 0;
        stray = 0;
        drive_req(v, name);
        @(negedge clk);
        if (v.exp_err) begin
            check({name, "_err_pulse"}, err, 1);
            check({name, "_err_no_we"}, we, 0);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (we !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1) stray++;
            end
            check({name, "_err_quiet"}, stray, 0);
            return;
        end
        check({name, "_latency"}, we, 1);
        while (we === 1'b1 && n < 60) begin
            if (Indata !== exp_byte(v, n) || busy !== 1'b1 || done !== 1'b0) bad++;
            n++;
            req_valid = (n == pulse_at);
            if (n == reset_at) reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
        req_valid = 1'b0;
        check({name, "_bytes"}, bad, 0);
        if (reset_at > 0) begin
            check({name, "_abort_len"}, n, reset_at);
            check({name, "_abort_idata"}, Indata, 0);
            check({name, "_abort_ready"}, {req_ready, busy}, 2'b10);
            for (int c = 0; c < 5; c++) begin
                if (done !== 1'b0 || we !== 1'b0) stray++;
                @(negedge clk);
            end
            check({name, "_abort_no_done"}, stray, 0);
            return;
        end
        check({name, "_len"}, n, v.exp_len);
        check({name, "_done"}, done, 1);
        check({name, "_idle_idata"}, Indata, 0);
        check({name, "_post_busy"}, busy, (GAP > 0));
        @(negedge clk);
        check({name, "_done_1cyc"}, done, 0);
        if (pulse_at > 0) begin
            for (int c = 0; c < 20; c++) begin
                if (we !== 1'b0) stray++;
                @(negedge clk);
            end
            check({name, "_no_second"}, stray, 0);
        end
    endtask

    initial begin
        vecs[0] = '{128'h00112233445566778899aabbccddeeff,
                    {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    2'd0, 8'h01, 34, 8'h10, 1'b0};
        vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734,
                    {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    2'd1, 8'h02, 42, 8'h18, 1'b0};
        vecs[2] = '{128'hffeeddccbbaa99887766554433221100,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    2'd2, 8'h01, 50, 8'h20, 1'b0};
`ifdef AES_SERIALIZER_KSIZE_CHECK_EN
        vecs[3] = '{128'h0123456789abcdef0123456789abcdef,
                    256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebf,
                    2'd3, 8'h01, 0, 8'h10, 1'b1};
`else
        vecs[3] = '{128'h0123456789abcdef0123456789abcdef,
                    256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebf,
                    2'd3, 8'h01, 34, 8'h10, 1'b0};
`endif

        reset     = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        req_key   = '0;
        req_ksize = 2'd0;
        req_op    = 8'h00;
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_we", we, 0);
        check("rst_idata", Indata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i), 0, 0);
        end

        // Back-to-back frames with req_valid held high.
        begin
            int starts;
            int dones;
            int zeros;
            int gap_between;
            int len1;
            logic prev_we;
            starts = 0;
            dones = 0;
            zeros = 0;
            gap_between = -1;
            len1 = 0;
            prev_we = 1'b0;
            drive_req(vecs[0], "b2b");
            req_valid = 1'b1;
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                if (done === 1'b1) dones++;
                if (we === 1'b1 && prev_we === 1'b0) begin
                    starts++;
                    if (starts == 2) begin
                        gap_between = zeros;
                        req_valid = 1'b0;
                    end
                end
                if (we === 1'b1 && starts == 1) len1++;
                zeros = (we === 1'b1) ? 0 : zeros + 1;
                prev_we = we;
            end
            req_valid = 1'b0;
            check("b2b_frames", starts, 2);
            check("b2b_gap", gap_between, GAP + 1);
            check("b2b_dones", dones, 2);
            check("b2b_len1", len1, 34);
        end

        run_frame(vecs[2], "rst_mid", 0, 20);
        run_frame(vecs[0], "after_rst", 0, 0);
        run_frame(vecs[1], "pulse", 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_cmd_serializer.md
AES_CMD_SERIALIZER -- requirements
Module: aes_cmd_serializer

Interface
REQ-001 Parameter GAP_CYCLES, default 1: idle cycles with we=0 after each frame before req_ready reasserts; legal range 0..15.
REQ-002 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_data  input  128  plaintext/ciphertext block; byte 0 = req_data[127:120].
REQ-008 req_key  input  256  key, left-aligned; byte 0 = req_key[255:248].
REQ-009 req_ksize  input  2  0=128b, 1=192b, 2=256b, 3=invalid.
REQ-010 req_op  input  8  process code (8'h01 = encrypt).
REQ-011 we  output  1  byte strobe to AES core.
REQ-012 Indata  output  8  byte to AES core.
REQ-013 busy  output  1  frame in progress or gap active.
REQ-014 done  output  1  one-cycle pulse in the cycle after the last frame byte.
REQ-015 err  output  1  one-cycle pulse on rejected request.

Function
REQ-016 The block SHALL capture req_data, req_key, req_ksize and req_op on the clock edge where req_valid and req_ready are both 1; inputs are don't-care at other times.
REQ-017 The FSM SHALL have states IDLE, DATA, KSIZE, KEY, PROC, GAP.
REQ-018 IDLE: req_ready=1, we=0; on accept go to DATA; first byte appears on the next edge.
REQ-019 DATA: 16 cycles, we=1, Indata = data bytes 0..15 in order, MSB first.
REQ-020 KSIZE: 1 cycle, we=1, Indata = key length in bytes (8'h10/8'h18/8'h20).
REQ-021 KEY: N = 16/24/32 cycles, we=1, Indata = key bytes 0..N-1, MSB first.
REQ-022 PROC: 1 cycle, we=1, Indata = captured req_op.
REQ-023 Frame SHALL be contiguous: we high for exactly 34/42/50 consecutive cycles, no bubbles.
REQ-024 done pulses in the first cycle after PROC; FSM enters GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
REQ-025 GAP: we=0, req_ready=0 for GAP_CYCLES cycles, then IDLE.
REQ-026 Latency: accept edge to first we=1 cycle is exactly 1 cycle; back-to-back frames with GAP_CYCLES=0 are separated by exactly 1 IDLE cycle.
REQ-027 When we=0, Indata SHALL be 8'h00.
REQ-028 busy = 1 in every state except IDLE.
REQ-029 The byte counter SHALL be 6 bits and SHALL clear on every state transition; no wrap-around inside a state.
REQ-030 req_valid while busy SHALL be ignored (not queued); the request is held upstream until req_ready.

Reset
REQ-031 reset=1 at a clock edge SHALL force state IDLE, counter 0, we=0, Indata=8'h00, done=0, err=0, busy=0, and req_ready=1 from the following cycle.
REQ-032 Reset mid-frame SHALL abort the frame: we drops on the reset edge and no done pulse is emitted; reset wins over a simultaneous accept.

Configuration
REQ-033 Macro AES_SERIALIZER_KSIZE_CHECK_EN: when defined, an accept with req_ksize=3 SHALL pulse err for one cycle, emit no bytes, and stay in IDLE.
REQ-034 Without AES_SERIALIZER_KSIZE_CHECK_EN, req_ksize=3 SHALL be treated as 128-bit (2'd0), err SHALL be tied 0, and no check logic is compiled.

Structure
REQ-035 Shared package aes_pkg SHALL hold the state enum, the ksize encoding constants, the byte-length constants (16, 24, 32), and OP_ENCRYPT=8'h01.
REQ-036 The block SHALL be a single module; the 128b data and 256b key shift registers are inline, with no sub-module.

Verification
REQ-037 FIPS-197 frame: data 00112233..eeff, key 000102..0f, ksize 0, op 01 -> 34 contiguous we cycles carrying 00,11,..,ff,10,00,01,..,0f,01; done 1 cycle later; the core output equals 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-038 256-bit key 000102..1f, ksize 2 -> KSIZE byte 8'h20, 32 key bytes 00..1f, total 50 we cycles.
REQ-039 Back-to-back requests with GAP_CYCLES=0 and req_valid held high -> exactly one we=0 cycle between frames and two done pulses.
REQ-040 reset asserted on the 20th byte of a frame -> we=0 on that edge, no done, req_ready=1 next cycle, next frame correct.
REQ-041 ksize=3 with the macro defined -> err pulse, we never asserted; without the macro -> a 34-byte frame with KSIZE byte 8'h10.
REQ-042 req_valid pulsed during DATA -> ignored; frame bytes unchanged, no second frame.
